param_updown_counter: RTL
=========================

Name: param_updown_counter

Overview:
- Parametrised successor to the 4-bit synchronous up counter and down counter.
- Configurable width, modulo limit, up/down direction, wrap or saturate mode, synchronous clear and parallel load.
- Optional prescaler sets the count rate; registered event flags are provided.
- Used as a general-purpose event/timer counter in the sequential library and instantiated by timers and dividers.

Parameters:
- WIDTH, 4: counter width in bits (2..32).
- MAX_VAL, 2**WIDTH-1: terminal value in the up direction; count range is 0..MAX_VAL.
- SATURATE, 0: 0 = wrap (MAX_VAL->0 up, 0->MAX_VAL down); 1 = hold at the limit.
- PRESCALE, 1: count step occurs once every PRESCALE enabled clocks (1..65535).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  count enable; also gates the prescaler.
- up_dn  in  1  1 = count up, 0 = count down; sampled each cycle.
- clear  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count (registered).
- tc  out  1  combinational terminal count: enable & step & (up_dn ? count==MAX_VAL : count==0).
- wrap  out  1  registered one-cycle pulse, cycle after a wrap or saturation-blocked step.
- at_limit  out  1  registered: count==MAX_VAL or count==0.

Behaviour:
- Reset (rst=0, asynchronous): count=0, wrap=0, at_limit=1, prescaler=0. Release is synchronous to the next clk edge.
- Priority per edge is clear > load > count. Clear and load also reset the prescaler to 0.
- Load clamping: load_val > MAX_VAL loads MAX_VAL.
- Prescaler:
  - Internal counter pre runs 0..PRESCALE-1 and advances only when enable=1.
  - step = enable & (pre==PRESCALE-1).
  - With PRESCALE=1, step=enable and the prescaler logic is removed.
  - enable=0 freezes both pre and count (hold, no loss of phase).
- Count step, when step=1:
  - Up, count<MAX_VAL: count+1.
  - Down, count>0: count-1.
  - Up at MAX_VAL: 0 if SATURATE=0, else hold.
  - Down at 0: MAX_VAL if SATURATE=0, else hold.
  - Either limit case sets wrap=1 on the next cycle.
- Latency: count changes on the edge where step=1. tc is high in the same cycle as that step. wrap is high the following cycle only.
- up_dn changing mid-prescale takes effect on the next step. There is no re-phase.
- Arithmetic is WIDTH bits, unsigned. Comparisons are against MAX_VAL cast to WIDTH. Elaboration error if MAX_VAL >= 2**WIDTH or PRESCALE < 1.
- Simultaneous events:
  - clear with load: clear wins, wrap=0.
  - load at a terminal with step: load wins, no wrap pulse.
- Reset mid-count: immediate asynchronous return to the reset values. No pulse on wrap.

Decomposition:
- Package counter_pkg: mode constants CNT_WRAP=0 and CNT_SAT=1, and a function clamp_load(val, max).
- One sub-module: counter_prescaler.
  - Parameters: PRESCALE.
  - Ports: clk, rst, enable, sync_clr, tick.
  - Instantiated only when PRESCALE>1.

Test Plan:
- Basic up/wrap: WIDTH=4, MAX_VAL=9, SATURATE=0, enable=1, up_dn=1 for 12 clocks after reset -> count 1..9,0,1,2; tc=1 while count=9; wrap=1 only the cycle count first reads 0.
- Down/saturate: SATURATE=1, load_val=2, load for 1 cycle, then up_dn=0 for 5 clocks -> count 2,1,0,0,0; wrap pulses once per blocked step (3 pulses); at_limit=1 from count=0.
- Hold and priority: count=5, enable=0 for 3 cycles -> holds 5; then clear=1 and load=1 with load_val=7 together -> count=0; then load_val=15 with MAX_VAL=9 -> count=9.
- Prescaler: PRESCALE=3, enable toggled 1,1,0,1 -> count increments only on the 3rd enabled clock; tc is asserted only on the step cycle.
- Async reset mid-run: count=6, pull rst low between edges -> count=0 immediately; wrap=0; counting resumes from 1 on the second edge after release.
- Direction change: counting up at 4, set up_dn=0 -> next step gives 3; wrap stays 0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter family.
package counter_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // Loads above the terminal value are pinned to the terminal value.
    function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Rate divider: emits a one-cycle tick on every PRESCALE-th enabled clock.
module counter_prescaler #(
    parameter int PRESCALE = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_sync_clr,
    output logic o_tick
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre;

    assign o_tick = i_enable & (r_pre == LAST);

    // Disabled clocks freeze the phase rather than resetting it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre <= '0;
        end else if (i_sync_clr) begin
            r_pre <= '0;
        end else if (i_enable) begin
            r_pre <= (r_pre == LAST) ? '0 : r_pre + PW'(1);
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// General-purpose up/down event counter with modulo limit, wrap/saturate,
// clear, clamped load, optional prescaler and registered event flags.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MAX_VAL  = (longint'(1) << WIDTH) - 1,
    parameter int     SATURATE = CNT_WRAP,
    parameter int     PRESCALE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_up_dn,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_wrap,
    output logic             o_at_limit
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("param_updown_counter: WIDTH must be 2..32");
        end
        if (MAX_VAL < 0 || MAX_VAL >= (longint'(1) << WIDTH)) begin : g_bad_max
            $error("param_updown_counter: MAX_VAL must fit in WIDTH bits");
        end
        if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
            $error("param_updown_counter: PRESCALE must be 1..65535");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic             r_run;
    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_at_limit;

    logic             w_enable;
    logic             w_clear;
    logic             w_load;
    logic             w_step;
    logic             w_at_term;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_count_next;
    logic             w_wrap_next;

    // r_run holds the counter idle for the first edge after reset release.
    assign w_enable   = i_enable & r_run;
    assign w_clear    = i_clear & r_run;
    assign w_load     = i_load & r_run;
    assign w_load_val = WIDTH'(clamp_load(32'(i_load_val), 32'(MAX_W)));
    assign w_at_term  = i_up_dn ? (r_count == MAX_W) : (r_count == '0);

    generate
        if (PRESCALE > 1) begin : g_prescale
            counter_prescaler #(
                .PRESCALE (PRESCALE)
            ) u_prescaler (
                .i_clk      (i_clk),
                .i_rst_n    (i_rst_n),
                .i_enable   (w_enable),
                .i_sync_clr (w_clear | w_load),
                .o_tick     (w_step)
            );
        end else begin : g_no_prescale
            assign w_step = w_enable;
        end
    endgenerate

    always_comb begin
        w_count_next = r_count;
        w_wrap_next  = 1'b0;
        if (w_clear) begin
            w_count_next = '0;
        end else if (w_load) begin
            w_count_next = w_load_val;
        end else if (w_step) begin
            if (w_at_term) begin
                w_wrap_next = 1'b1;
                if (SATURATE != CNT_SAT) begin
                    w_count_next = i_up_dn ? '0 : MAX_W;
                end
            end else begin
                w_count_next = i_up_dn ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run      <= 1'b0;
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_at_limit <= 1'b1;
        end else begin
            r_run      <= 1'b1;
            r_count    <= w_count_next;
            r_wrap     <= w_wrap_next;
            r_at_limit <= (w_count_next == MAX_W) || (w_count_next == '0);
        end
    end

    assign o_count    = r_count;
    assign o_tc       = w_step & w_at_term;
    assign o_wrap     = r_wrap;
    assign o_at_limit = r_at_limit;

endmodule
